spi_slave_stream: RTL

//  Parametrised SPI slave; sits between an external SPI master and on-chip register/PWM logic.

---
 rtl/spi_slave_stream_if.sv | 24 ++
 rtl/spi_slave_stream.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_stream_if.sv
// Stream-side bundle of the SPI slave: RX word strobe, TX holding-buffer handshake and frame status.
interface spi_slave_stream_if #(
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic [BIT_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_underrun;
  logic                 frame_end;
  logic                 frame_partial;
  logic                 busy;

  modport slave (
    input  tx_data, tx_valid,
    output rx_data, rx_valid, tx_ready, tx_underrun, frame_end, frame_partial, busy
  );

  modport master (
    output tx_data, tx_valid,
    input  rx_data, rx_valid, tx_ready, tx_underrun, frame_end, frame_partial, busy
  );
endinterface

// File: rtl/spi_slave_stream.sv
// SPI slave (any CPOL/CPHA, either bit order) with a one-word TX holding buffer, all pins oversampled in clk.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release miso (1'bz) while deselected or not armed.
module spi_slave_stream #(
  parameter int BIT_WIDTH = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic ssel,
  input  logic mosi,
  output logic miso,
  spi_slave_stream_if.slave bus
);
  localparam int CW = $clog2(BIT_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(BIT_WIDTH - 1);
  localparam bit CPOL_B = (CPOL != 0);
  localparam bit CPHA_B = (CPHA != 0);
  localparam bit LSB_B  = (LSB_FIRST != 0);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_ACTIVE} state_t;

  state_t state, state_next;
  logic [2:0] sck_s, ssel_s;
  logic [1:0] mosi_s;
  logic [1:0] flush_cnt;
  logic [CW-1:0] bitcnt;
  logic [BIT_WIDTH-1:0] rx_shift, rx_next, rx_data_q, tx_shift, hold;
  logic hold_full, rx_valid_q, underrun_q, frame_end_q, partial_q;
  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ssel_fall, ssel_rise, tx_bit;
  logic word_start, do_sample, do_shift, frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s  <= {3{CPOL_B}};
      ssel_s <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sck_s  <= {sck_s[1:0], sck};
      ssel_s <= {ssel_s[1:0], ssel};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign sck_rise    = sck_s[1] & ~sck_s[2];
  assign sck_fall    = ~sck_s[1] & sck_s[2];
  assign lead_edge   = CPOL_B ? sck_fall : sck_rise;
  assign trail_edge  = CPOL_B ? sck_rise : sck_fall;
  assign sample_edge = CPHA_B ? trail_edge : lead_edge;
  assign shift_edge  = CPHA_B ? lead_edge : trail_edge;
  assign ssel_fall   = ssel_s[2] & ~ssel_s[1];
  assign ssel_rise   = ~ssel_s[2] & ssel_s[1];

  assign rx_next = LSB_B ? {mosi_s[1], rx_shift[BIT_WIDTH-1:1]} : {rx_shift[BIT_WIDTH-2:0], mosi_s[1]};
  assign tx_bit  = LSB_B ? tx_shift[0] : tx_shift[BIT_WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) state <= S_FLUSH;
    else       state <= state_next;
  end

  // FLUSH waits until stages [2:1] hold real samples, so an SSEL already low at reset release never arms.
  always_comb begin
    state_next = state;
    word_start = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_FLUSH: if (flush_cnt == 2'd2) state_next = S_IDLE;
      S_IDLE: begin
        if (ssel_fall) begin
          state_next = S_ACTIVE;
          word_start = !CPHA_B;
        end
      end
      S_ACTIVE: begin
        if (ssel_rise) begin
          state_next = S_IDLE;
          frame_done = 1'b1;
        end else begin
          do_sample = sample_edge;
          if (shift_edge) begin
            if (bitcnt == '0) word_start = 1'b1;
            else              do_shift   = 1'b1;
          end
        end
      end
      default: state_next = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt   <= 2'd0;
      bitcnt      <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift    <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
      partial_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
      partial_q   <= 1'b0;
      if (state == S_FLUSH) flush_cnt <= flush_cnt + 2'd1;
      if (do_sample) begin
        rx_shift <= rx_next;
        if (bitcnt == LAST_BIT) begin
          bitcnt     <= '0;
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end else begin
          bitcnt <= bitcnt + CW'(1);
        end
      end
      if (frame_done) begin
        frame_end_q <= 1'b1;
        partial_q   <= (bitcnt != '0);
        bitcnt      <= '0;
      end
      if (word_start) begin
        tx_shift   <= hold_full ? hold : '0;
        underrun_q <= !hold_full;
      end else if (do_shift) begin
        tx_shift <= LSB_B ? {1'b0, tx_shift[BIT_WIDTH-1:1]} : {tx_shift[BIT_WIDTH-2:0], 1'b0};
      end
      // A write landing on a word start fills the hold for the next word; it never bypasses.
      if (bus.tx_valid && !hold_full) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (word_start && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (ssel || state != S_ACTIVE) ? 1'bz : tx_bit;
`else
  assign miso = tx_bit;
`endif

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.tx_ready      = !hold_full;
  assign bus.tx_underrun   = underrun_q;
  assign bus.frame_end     = frame_end_q;
  assign bus.frame_partial = partial_q;
  assign bus.busy          = (state == S_ACTIVE);
endmodule
